// File: rtl/spi_cmd_ram.sv
// SPI command RAM: decodes 2-bit-opcode command words into writes/reads of a register array and
// returns read data through a tx_valid/tx_ready handshake with overrun and timeout status.
module spi_cmd_ram #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned MEM_DEPTH  = 256,
   parameter int unsigned AUTO_INC   = 1,
   parameter int unsigned TX_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W+1:0] din_i,
   input  logic              rx_valid_i,
   input  logic              tx_ready_i,
   output logic [DATA_W-1:0] dout_o,
   output logic              tx_valid_o,
   output logic              overrun_o,
   output logic              timeout_err_o
);

   localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int unsigned CNT_W = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TX_TIMEOUT);

   typedef enum logic {StIdle, StTxWait} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   dout_q, dout_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                overrun_q, overrun_d;
   logic                timeout_err_q, timeout_err_d;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

   logic [1:0]          opcode;
   logic [DATA_W-1:0]   payload;
   logic                wr_in_range, rd_in_range;
   logic [CNT_W-1:0]    cnt_inc;

   assign opcode      = din_i[DATA_W+1:DATA_W];
   assign payload     = din_i[DATA_W-1:0];
   assign wr_in_range = 32'(wr_addr_q) < MEM_DEPTH;
   assign rd_in_range = 32'(rd_addr_q) < MEM_DEPTH;
   assign cnt_inc     = cnt_q + 1'b1;

   // Wraps at the last implemented word; out-of-range addresses just count upward.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a == ADDR_LAST) ? '0 : a + 1'b1;
   endfunction

   always_comb begin
      state_d       = state_q;
      dout_d        = dout_q;
      wr_addr_d     = wr_addr_q;
      rd_addr_d     = rd_addr_q;
      cnt_d         = cnt_q;
      overrun_d     = overrun_q;
      timeout_err_d = timeout_err_q;
      mem_we        = 1'b0;

      if (state_q == StTxWait) begin
         if (tx_ready_i) begin
            state_d = StIdle;
         end else if (TX_TIMEOUT > 0) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
               state_d       = StIdle;
               timeout_err_d = 1'b1;
            end
         end
      end

      if (rx_valid_i) begin
         unique case (opcode)
            2'b00: wr_addr_d = payload[ADDR_W-1:0];
            2'b01: begin
               mem_we = wr_in_range;
               if (AUTO_INC != 0) wr_addr_d = next_addr(wr_addr_q);
            end
            2'b10: rd_addr_d = payload[ADDR_W-1:0];
            2'b11: begin
               // State as sampled decides; a same-edge tx_ready does not free the slot.
               if (state_q == StIdle) begin
                  dout_d  = rd_in_range ? mem_q[rd_addr_q[IDX_W-1:0]] : '0;
                  state_d = StTxWait;
                  cnt_d   = '0;
                  if (AUTO_INC != 0) rd_addr_d = next_addr(rd_addr_q);
               end else begin
                  overrun_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         dout_q        <= '0;
         wr_addr_q     <= '0;
         rd_addr_q     <= '0;
         cnt_q         <= '0;
         overrun_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dout_q        <= dout_d;
         wr_addr_q     <= wr_addr_d;
         rd_addr_q     <= rd_addr_d;
         cnt_q         <= cnt_d;
         overrun_q     <= overrun_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Storage is deliberately left out of reset so contents survive it.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[wr_addr_q[IDX_W-1:0]] <= payload;
   end

   assign dout_o        = dout_q;
   assign tx_valid_o    = (state_q == StTxWait);
   assign overrun_o     = overrun_q;
   assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Self-checking bench for spi_cmd_ram: a default instance plus a MEM_DEPTH=200 instance for
// out-of-range addressing; read data expectations flow through a scoreboard queue.
module tb_spi_cmd_ram;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] din = '0, o_din = '0;
   logic       rx_valid = 1'b0, o_rx_valid = 1'b0;
   logic       tx_ready = 1'b0, o_tx_ready = 1'b0;
   logic [7:0] dout, o_dout;
   logic       tx_valid, o_tx_valid, overrun, o_overrun, terr, o_terr;

   logic [7:0] exp_q [$];
   logic [7:0] exp;
   int         n_checks = 0;
   int         n_errors = 0;

   always #5 clk = ~clk;

   spi_cmd_ram dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din_i         (din),
      .rx_valid_i    (rx_valid),
      .tx_ready_i    (tx_ready),
      .dout_o        (dout),
      .tx_valid_o    (tx_valid),
      .overrun_o     (overrun),
      .timeout_err_o (terr)
   );

   spi_cmd_ram #(.MEM_DEPTH(200)) dut_oor (
      .clk           (clk),
      .rst_n         (rst_n),
      .din_i         (o_din),
      .rx_valid_i    (o_rx_valid),
      .tx_ready_i    (o_tx_ready),
      .dout_o        (o_dout),
      .tx_valid_o    (o_tx_valid),
      .overrun_o     (o_overrun),
      .timeout_err_o (o_terr)
   );

   // One command per call; returns 1 time unit after the sampling edge.
   task automatic cmd(input bit sel, input logic [1:0] op, input logic [7:0] pl);
      if (!sel) begin
         din = {op, pl};
         rx_valid = 1'b1;
      end else begin
         o_din = {op, pl};
         o_rx_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      o_rx_valid = 1'b0;
   endtask

   task automatic ack(input bit sel);
      if (!sel) tx_ready = 1'b1;
      else o_tx_ready = 1'b1;
      @(posedge clk);
      #1;
      tx_ready = 1'b0;
      o_tx_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #2;
      n_checks++;
      if ({tx_valid, dout, overrun, terr} !== 11'h0) begin
         n_errors++;
         $display("FAIL reset_outputs: got tv=%b dout=%h ov=%b te=%b, want all 0",
                  tx_valid, dout, overrun, terr);
      end
      n_checks++;
      if ({o_tx_valid, o_dout, o_overrun, o_terr} !== 11'h0) begin
         n_errors++;
         $display("FAIL reset_outputs_oor: got tv=%b dout=%h ov=%b te=%b, want all 0",
                  o_tx_valid, o_dout, o_overrun, o_terr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic;
      cmd(0, 2'b00, 8'h05);
      cmd(0, 2'b01, 8'hA5);
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL basic_tx_valid: got %b want 1", tx_valid);
      end
      n_checks++;
      if (dout !== exp) begin
         n_errors++;
         $display("FAIL basic_dout: got %h want %h", dout, exp);
      end
      ack(0);
      n_checks++;
      if (tx_valid !== 1'b0 || dout !== 8'hA5) begin
         n_errors++;
         $display("FAIL basic_release: got tv=%b dout=%h want tv=0 dout=a5", tx_valid, dout);
      end
   endtask

   task automatic test_burst;
      cmd(0, 2'b00, 8'hFE);
      cmd(0, 2'b01, 8'h11);
      cmd(0, 2'b01, 8'h22);
      cmd(0, 2'b01, 8'h33);
      cmd(0, 2'b10, 8'hFE);
      for (int i = 0; i < 3; i++) begin
         cmd(0, 2'b11, 8'h00);
         exp_q.push_back(8'((i + 1) * 8'h11));
         exp = exp_q.pop_front();
         n_checks++;
         if (tx_valid !== 1'b1 || dout !== exp) begin
            n_errors++;
            $display("FAIL burst_read%0d: got tv=%b dout=%h want tv=1 dout=%h",
                     i, tx_valid, dout, exp);
         end
         ack(0);
      end
   endtask

   task automatic test_overrun;
      cmd(0, 2'b00, 8'h06);
      cmd(0, 2'b01, 8'h66);
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      n_checks++;
      if (overrun !== 1'b0) begin
         n_errors++;
         $display("FAIL overrun_pre: got %b want 0", overrun);
      end
      cmd(0, 2'b11, 8'h00);
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || dout !== exp || overrun !== 1'b1) begin
         n_errors++;
         $display("FAIL overrun_hold: got tv=%b dout=%h ov=%b want tv=1 dout=%h ov=1",
                  tx_valid, dout, overrun, exp);
      end
      ack(0);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'h66);
      exp = exp_q.pop_front();
      n_checks++;
      if (dout !== exp) begin
         n_errors++;
         $display("FAIL overrun_rd_addr: got dout=%h want %h", dout, exp);
      end
      ack(0);
   endtask

   task automatic test_timeout;
      // tx_ready arrives on the 16th TX_WAIT cycle: handshake wins over expiry
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 15; i++) begin
         n_checks++;
         if (tx_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL to_ready_hold%0d: got tv=%b want 1", i, tx_valid);
         end
         @(posedge clk);
         #1;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || dout !== exp) begin
         n_errors++;
         $display("FAIL to_ready_16th: got tv=%b dout=%h want tv=1 dout=%h", tx_valid, dout, exp);
      end
      ack(0);
      n_checks++;
      if (tx_valid !== 1'b0 || terr !== 1'b0) begin
         n_errors++;
         $display("FAIL to_ready_wins: got tv=%b te=%b want tv=0 te=0", tx_valid, terr);
      end
      // tx_ready never arrives
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      for (int i = 0; i < 16; i++) begin
         n_checks++;
         if (tx_valid !== 1'b1 || terr !== 1'b0) begin
            n_errors++;
            $display("FAIL to_hold%0d: got tv=%b te=%b want tv=1 te=0", i, tx_valid, terr);
         end
         @(posedge clk);
         #1;
      end
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b0 || terr !== 1'b1 || dout !== exp) begin
         n_errors++;
         $display("FAIL to_expire: got tv=%b te=%b dout=%h want tv=0 te=1 dout=%h",
                  tx_valid, terr, dout, exp);
      end
   endtask

   task automatic test_out_of_range;
      cmd(1, 2'b00, 8'h00);
      cmd(1, 2'b01, 8'h12);
      cmd(1, 2'b00, 8'hC8);
      cmd(1, 2'b01, 8'h55);
      cmd(1, 2'b10, 8'hC8);
      cmd(1, 2'b11, 8'h00);
      exp_q.push_back(8'h00);
      exp = exp_q.pop_front();
      n_checks++;
      if (o_tx_valid !== 1'b1 || o_dout !== exp) begin
         n_errors++;
         $display("FAIL oor_read: got tv=%b dout=%h want tv=1 dout=%h", o_tx_valid, o_dout, exp);
      end
      ack(1);
      cmd(1, 2'b10, 8'h00);
      cmd(1, 2'b11, 8'h00);
      exp_q.push_back(8'h12);
      exp = exp_q.pop_front();
      n_checks++;
      if (o_dout !== exp) begin
         n_errors++;
         $display("FAIL oor_no_alias: got dout=%h want %h", o_dout, exp);
      end
      ack(1);
      // Last word wraps the write and read pointers to 0
      cmd(1, 2'b00, 8'hC7);
      cmd(1, 2'b01, 8'h77);
      cmd(1, 2'b01, 8'h34);
      cmd(1, 2'b10, 8'hC7);
      for (int i = 0; i < 2; i++) begin
         cmd(1, 2'b11, 8'h00);
         exp_q.push_back((i == 0) ? 8'h77 : 8'h34);
         exp = exp_q.pop_front();
         n_checks++;
         if (o_tx_valid !== 1'b1 || o_dout !== exp) begin
            n_errors++;
            $display("FAIL oor_wrap%0d: got tv=%b dout=%h want tv=1 dout=%h",
                     i, o_tx_valid, o_dout, exp);
         end
         ack(1);
      end
   endtask

   task automatic test_reset_mid;
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || dout !== exp || overrun !== 1'b1 || terr !== 1'b1) begin
         n_errors++;
         $display("FAIL rstmid_pre: got tv=%b dout=%h ov=%b te=%b want 1 %h 1 1",
                  tx_valid, dout, overrun, terr, exp);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tx_valid, dout, overrun, terr} !== 11'h0) begin
         n_errors++;
         $display("FAIL rstmid_async: got tv=%b dout=%h ov=%b te=%b want all 0",
                  tx_valid, dout, overrun, terr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (tx_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_no_glitch%0d: got tv=%b want 0", i, tx_valid);
         end
      end
      cmd(0, 2'b10, 8'h05);
      cmd(0, 2'b11, 8'h00);
      exp_q.push_back(8'hA5);
      exp = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || dout !== exp) begin
         n_errors++;
         $display("FAIL rstmid_mem_kept: got tv=%b dout=%h want tv=1 dout=%h", tx_valid, dout, exp);
      end
      ack(0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_burst();
      test_overrun();
      test_timeout();
      test_out_of_range();
      test_reset_mid();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_cmd_ram.md
Name: spi_cmd_ram

Overview:
- Parametrised successor of the SPI-slave command RAM. Sits behind the SPI slave deserialiser and decodes 2-bit-opcode command words into address/data writes and reads of an internal register-array memory.
- Adds independent address/data widths, optional address auto-increment for burst transfers, and a tx_valid/tx_ready handshake toward the SPI transmit shifter.
- Adds overrun and timeout status flags.

Parameters:
- DATA_W, 8, data word width; command payload width.
- ADDR_W, 8, address width; must satisfy ADDR_W <= DATA_W.
- MEM_DEPTH, 256, number of words; must satisfy MEM_DEPTH <= 2**ADDR_W.
- AUTO_INC, 1, 1 enables post-increment of wr_addr/rd_addr on data commands; 0 disables it.
- TX_TIMEOUT, 16, cycles tx_valid may wait for tx_ready before abandoning the word; 0 disables the timeout.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, DATA_W+2, command word: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
- rx_valid, input, 1, din valid this cycle; one command is consumed per asserted cycle.
- tx_ready, input, 1, transmit shifter accepts dout this cycle.
- dout, output, DATA_W, read data.
- tx_valid, output, 1, dout valid; held until accepted or timed out.
- overrun, output, 1, sticky: a read command was dropped.
- timeout_err, output, 1, sticky: a read word was abandoned by timeout.

Behaviour:
- Reset (asynchronous, rst_n=0): dout=0, tx_valid=0, overrun=0, timeout_err=0, wr_addr=0, rd_addr=0, timeout counter=0, state=IDLE. Memory is not reset; contents persist across reset and are undefined at power-up.
- States:
  - IDLE: tx_valid=0.
  - TX_WAIT: tx_valid=1, dout stable.
- Opcode decode, acted on only when rx_valid=1 at a rising edge:
  - 00: wr_addr <= payload[ADDR_W-1:0].
  - 01: mem[wr_addr] <= payload. If AUTO_INC=1, wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0. If wr_addr >= MEM_DEPTH the write is ignored, but the increment still applies.
  - 10: rd_addr <= payload[ADDR_W-1:0].
  - 11, state IDLE: dout <= mem[rd_addr] (0 if rd_addr >= MEM_DEPTH), tx_valid <= 1, state -> TX_WAIT, timeout counter cleared. If AUTO_INC=1, rd_addr increments with the same wrap rule.
  - 11, state TX_WAIT: command dropped, overrun <= 1. dout, rd_addr and state are unchanged.
- Latency: a read command sampled at edge N gives dout/tx_valid valid after edge N (1 cycle).
- A write in cycle N is visible to a read sampled in cycle N+1 or later.
- Commands 00/01/10 are always processed in TX_WAIT; they never disturb dout or tx_valid.
- TX_WAIT exit on tx_ready=1 at an edge: tx_valid <= 0, dout retains its last value, state -> IDLE.
- Same-edge cases in TX_WAIT:
  - tx_ready=1 together with a read command: the read is treated as an overrun, because the state was TX_WAIT when sampled.
  - tx_ready=1 together with timeout expiry: tx_ready wins and timeout_err is not set.
- Timeout (TX_TIMEOUT>0): counter increments each TX_WAIT cycle with tx_ready=0. When it reaches TX_TIMEOUT: tx_valid <= 0, timeout_err <= 1, state -> IDLE.
- The counter is wide enough to hold TX_TIMEOUT and never wraps.
- rx_valid=0: no register changes except handshake and timeout logic.
- overrun and timeout_err clear only on reset.
- Reset mid-TX_WAIT aborts the transfer immediately; there is no tx_valid glitch after rst_n deasserts.

Test Plan:
- Write 00_05, 01_A5, then read 10_05, 11_xx, tx_ready=1 one cycle after tx_valid -> dout=0xA5 one cycle after the read command, tx_valid drops the cycle after tx_ready.
- Burst with AUTO_INC=1: 00_FE, then 01_11, 01_22, 01_33 -> mem[FE]=11, mem[FF]=22, mem[00]=33. Read-back burst from 10_FE returns 11, 22, 33 in order.
- Overrun: two consecutive 11 commands with tx_ready=0 -> first data held on dout, overrun=1, rd_addr advanced once only.
- Timeout (TX_TIMEOUT=16): read with tx_ready held 0 -> tx_valid high exactly 16 cycles, then 0 with timeout_err=1. Same run with tx_ready=1 on the 16th cycle -> timeout_err stays 0.
- Out-of-range (MEM_DEPTH=200): write 00_C8, 01_55 -> no memory change. Read 10_C8, 11 -> dout=0.
- Reset asserted while in TX_WAIT -> tx_valid=0, dout=0, flags 0 without waiting for a clock edge. Previously written mem[05]=A5 is still readable after reset.
